// File: rtl/embed_filter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | embed_filter_if : AXI-Stream pixel channel (tvalid/tready/tdata/tuser) |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
interface embed_filter_if #(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int USER_WIDTH      = 2
);
    logic                       tvalid;
    logic                       tready;
    logic [PIXEL_BIT_WIDTH-1:0] tdata;
    logic [USER_WIDTH-1:0]      tuser;

    modport master (output tvalid, output tdata, output tuser, input  tready);
    modport slave  (input  tvalid, input  tdata, input  tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/embed_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | embed_filter : embeds a streamed IN_ROWS x IN_COLS window into a full  |
// | OUT_ROWS x OUT_COLS raster, padding everything else with FILL_VALUE.   |
// | Optional macro EMBED_SOF_CHECK_EN adds the sticky sof_err output.      |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module embed_filter #(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int USER_WIDTH      = 2,
    parameter int IN_ROWS         = 10,
    parameter int IN_COLS         = 10,
    parameter int OUT_ROWS        = 20,
    parameter int OUT_COLS        = 20,
    parameter int FILL_VALUE      = 0
) (
    input  wire                         clk,
    input  wire                         s_axis_resetn,
    input  wire                         ap_start,
    output logic                        ap_done,
    output logic                        ap_idle,
    input  wire  [$clog2(OUT_COLS)-1:0] place_x0,
    input  wire  [$clog2(OUT_ROWS)-1:0] place_y0,
    embed_filter_if.slave               s_axis,
    embed_filter_if.master              m_axis
`ifdef EMBED_SOF_CHECK_EN
    ,
    output logic                        sof_err
`endif
);

    localparam int CW = $clog2(OUT_COLS);
    localparam int RW = $clog2(OUT_ROWS);

    localparam logic [CW-1:0] c_X_MAX     = CW'(OUT_COLS - IN_COLS);
    localparam logic [RW-1:0] c_Y_MAX     = RW'(OUT_ROWS - IN_ROWS);
    localparam logic [CW-1:0] c_COL_LAST  = CW'(OUT_COLS - 1);
    localparam logic [RW-1:0] c_ROW_LAST  = RW'(OUT_ROWS - 1);
    localparam logic [CW:0]   c_IN_COLS_W = (CW+1)'(IN_COLS);
    localparam logic [RW:0]   c_IN_ROWS_W = (RW+1)'(IN_ROWS);
    localparam logic [PIXEL_BIT_WIDTH-1:0] c_FILL = PIXEL_BIT_WIDTH'(FILL_VALUE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     r_state;
    logic [1:0]                 r_rst_sync;
    logic                       w_rst_n;
    logic [CW-1:0]              r_col;
    logic [CW-1:0]              r_x0;
    logic [RW-1:0]              r_row;
    logic [RW-1:0]              r_y0;
    logic                       r_m_tvalid;
    logic [PIXEL_BIT_WIDTH-1:0] r_m_tdata;
    logic [USER_WIDTH-1:0]      r_m_tuser;
    logic                       r_ap_done;
    logic                       r_ap_idle;

    logic [CW-1:0]              w_x0_clamp;
    logic [RW-1:0]              w_y0_clamp;
    logic                       w_in_win;
    logic                       w_free;
    logic                       w_load;
    logic                       w_last;
    logic                       w_s_tready;
    logic [USER_WIDTH-1:0]      w_tuser;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    always_comb begin
        w_x0_clamp = (place_x0 > c_X_MAX) ? c_X_MAX : place_x0;
        w_y0_clamp = (place_y0 > c_Y_MAX) ? c_Y_MAX : place_y0;
        // Upper bounds are one bit wider than the counters so they cannot wrap.
        w_in_win   = (r_state == S_RUN)
                   && (r_col >= r_x0) && ({1'b0, r_col} < ({1'b0, r_x0} + c_IN_COLS_W))
                   && (r_row >= r_y0) && ({1'b0, r_row} < ({1'b0, r_y0} + c_IN_ROWS_W));
        w_free     = !r_m_tvalid || m_axis.tready;
        w_load     = (r_state == S_RUN) && w_free && (!w_in_win || s_axis.tvalid);
        w_s_tready = w_in_win && w_free;
        w_last     = (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);
        w_tuser    = '0;
        w_tuser[0] = (r_col == '0) && (r_row == '0);
        w_tuser[1] = (r_col == c_COL_LAST);
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= S_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_x0       <= '0;
            r_y0       <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tuser  <= '0;
            r_ap_done  <= 1'b0;
            r_ap_idle  <= 1'b1;
        end else begin
            r_ap_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_x0      <= w_x0_clamp;
                        r_y0      <= w_y0_clamp;
                        r_col     <= '0;
                        r_row     <= '0;
                        r_ap_idle <= 1'b0;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_load) begin
                        r_m_tvalid <= 1'b1;
                        r_m_tdata  <= w_in_win ? s_axis.tdata : c_FILL;
                        r_m_tuser  <= w_tuser;
                        if (r_col == c_COL_LAST) begin
                            r_col <= '0;
                            r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end
                    end else if (w_free) begin
                        r_m_tvalid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (r_m_tvalid && m_axis.tready) begin
                        r_m_tvalid <= 1'b0;
                        r_ap_done  <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ap_idle <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_axis.tready = w_s_tready;
    assign m_axis.tvalid = r_m_tvalid;
    assign m_axis.tdata  = r_m_tdata;
    assign m_axis.tuser  = r_m_tuser;
    assign ap_done       = r_ap_done;
    assign ap_idle       = r_ap_idle;

`ifdef EMBED_SOF_CHECK_EN
    logic r_sof_err;
    logic r_first_win;
    logic w_unused_tuser;

    assign w_unused_tuser = ^s_axis.tuser[USER_WIDTH-1:1];

    // Only the first accepted window beat of a frame may carry SOF.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sof_err   <= 1'b0;
            r_first_win <= 1'b0;
        end else if ((r_state == S_IDLE) && ap_start) begin
            r_sof_err   <= 1'b0;
            r_first_win <= 1'b1;
        end else if (s_axis.tvalid && w_s_tready) begin
            r_first_win <= 1'b0;
            if (s_axis.tuser[0] != r_first_win) begin
                r_sof_err <= 1'b1;
            end
        end
    end

    assign sof_err = r_sof_err;
`else
    logic w_unused_tuser;
    assign w_unused_tuser = ^s_axis.tuser;
`endif

endmodule
`default_nettype wire

// File: tb/tb_embed_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_embed_filter : scoreboard bench for embed_filter                   |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_embed_filter;

    localparam int PW    = 10;
    localparam int UW    = 2;
    localparam int IR    = 10;
    localparam int IC    = 10;
    localparam int OR    = 20;
    localparam int OC    = 20;
    localparam int N_IN  = IR * IC;
    localparam int N_OUT = OR * OC;

    typedef struct {
        logic [PW-1:0] d;
        logic [UW-1:0] u;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ap_start;
    logic       ap_done;
    logic       ap_idle;
    logic [4:0] place_x0;
    logic [4:0] place_y0;
`ifdef EMBED_SOF_CHECK_EN
    logic       sof_err;
`endif

    int    n_cmp = 0;
    int    n_err = 0;
    beat_t sb[$];

    embed_filter_if #(.PIXEL_BIT_WIDTH(PW), .USER_WIDTH(UW)) s_if ();
    embed_filter_if #(.PIXEL_BIT_WIDTH(PW), .USER_WIDTH(UW)) m_if ();

    embed_filter #(
        .PIXEL_BIT_WIDTH(PW), .USER_WIDTH(UW), .IN_ROWS(IR), .IN_COLS(IC),
        .OUT_ROWS(OR), .OUT_COLS(OC), .FILL_VALUE(0)
    ) dut (
        .clk           (clk),
        .s_axis_resetn (rst_n),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .place_x0      (place_x0),
        .place_y0      (place_y0),
        .s_axis        (s_if),
        .m_axis        (m_if)
`ifdef EMBED_SOF_CHECK_EN
        ,
        .sof_err       (sof_err)
`endif
    );

    always #5 clk = ~clk;

    // Reference raster: window pixels count up from 0, everything else is fill.
    task automatic push_frame(input int px, input int py);
        int x0, y0;
        beat_t b;
        x0 = (px > OC - IC) ? OC - IC : px;
        y0 = (py > OR - IR) ? OR - IR : py;
        for (int r = 0; r < OR; r++) begin
            for (int c = 0; c < OC; c++) begin
                if (r >= y0 && r < y0 + IR && c >= x0 && c < x0 + IC)
                    b.d = PW'((r - y0) * IC + (c - x0));
                else
                    b.d = '0;
                b.u = {(c == OC - 1), (r == 0 && c == 0)};
                sb.push_back(b);
            end
        end
    endtask

    task automatic start_frame(input int px, input int py);
        @(negedge clk);
        place_x0 = 5'(px);
        place_y0 = 5'(py);
        n_cmp++;
        if (ap_idle !== 1'b1) begin
            n_err++;
            $display("FAIL idle_before_start: got %b want 1", ap_idle);
        end
        ap_start = 1'b1;
        push_frame(px, py);
        @(negedge clk);
        ap_start = 1'b0;
        n_cmp++;
        if (ap_idle !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_start: got %b want 0", ap_idle);
        end
    endtask

    task automatic run_frame(input int stall, input bit bp, input bit gaps, input int abort_at,
                             input int sof_bad, output int gaps_out);
        int          pix, out_cnt, iter, stall_left;
        bit          hold, sof_exp;
        logic [PW-1:0] hd;
        logic [UW-1:0] hu;
        beat_t       e;
        pix = 0; out_cnt = 0; iter = 0; hold = 0; sof_exp = 0;
        gaps_out = 0; stall_left = stall;
        forever begin
            @(negedge clk);
            m_if.tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pix < N_IN) begin
                s_if.tvalid = (stall_left > 0) ? 1'b0 : (gaps ? ($urandom_range(0, 3) != 0) : 1'b1);
                s_if.tdata  = PW'(pix);
                s_if.tuser  = {1'b0, (pix == 0) || (pix == sof_bad)};
            end else begin
                s_if.tvalid = 1'b0;
            end
            #1;
            if (stall_left > 0 && s_if.tready === 1'b1) stall_left--;

            n_cmp++;
            if (ap_done !== 1'b0) begin
                n_err++;
                $display("FAIL ap_done_early: got %b want 0 at out beat %0d", ap_done, out_cnt);
            end
`ifdef EMBED_SOF_CHECK_EN
            n_cmp++;
            if (sof_err !== sof_exp) begin
                n_err++;
                $display("FAIL sof_err: got %b want %b after input %0d", sof_err, sof_exp, pix);
            end
`endif
            if (hold) begin
                n_cmp++;
                if (m_if.tvalid !== 1'b1 || m_if.tdata !== hd || m_if.tuser !== hu) begin
                    n_err++;
                    $display("FAIL hold_stable: got v=%b d=%0d u=%b want v=1 d=%0d u=%b",
                             m_if.tvalid, m_if.tdata, m_if.tuser, hd, hu);
                end
            end
            if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_beat: got d=%0d want no beat", m_if.tdata);
                end else begin
                    e = sb.pop_front();
                    if (m_if.tdata !== e.d || m_if.tuser !== e.u) begin
                        n_err++;
                        $display("FAIL beat %0d: got d=%0d u=%b want d=%0d u=%b",
                                 out_cnt, m_if.tdata, m_if.tuser, e.d, e.u);
                    end
                end
                out_cnt++;
            end else if (out_cnt > 0) begin
                gaps_out++;
            end
            hold = (m_if.tvalid === 1'b1) && (m_if.tready !== 1'b1);
            hd   = m_if.tdata;
            hu   = m_if.tuser;
            if (s_if.tvalid === 1'b1 && s_if.tready === 1'b1) begin
                if (pix == sof_bad) sof_exp = 1'b1;
                pix++;
            end
            if (out_cnt == N_OUT) break;
            if (abort_at > 0 && out_cnt == abort_at) return;
            iter++;
            if (iter > 6000) begin
                n_cmp++;
                n_err++;
                $display("FAIL timeout: got %0d beats want %0d", out_cnt, N_OUT);
                return;
            end
        end
        s_if.tvalid = 1'b0;
        n_cmp++;
        if (pix != N_IN) begin
            n_err++;
            $display("FAIL input_count: got %0d want %0d", pix, N_IN);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (ap_done !== 1'b1 || m_if.tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL ap_done_pulse: got done=%b valid=%b want done=1 valid=0", ap_done, m_if.tvalid);
        end
`ifdef EMBED_SOF_CHECK_EN
        n_cmp++;
        if (sof_err !== sof_exp) begin
            n_err++;
            $display("FAIL sof_err_end: got %b want %b", sof_err, sof_exp);
        end
`endif
        @(negedge clk); #1;
        n_cmp++;
        if (ap_done !== 1'b0 || ap_idle !== 1'b1) begin
            n_err++;
            $display("FAIL back_to_idle: got done=%b idle=%b want done=0 idle=1", ap_done, ap_idle);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL missing_beats: got %0d left want 0", sb.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0 || m_if.tvalid !== 1'b0 ||
            m_if.tdata !== '0 || m_if.tuser !== '0 || s_if.tready !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got idle=%b done=%b mv=%b md=%0d mu=%b sr=%b want 1 0 0 0 0 0", tag,
                     ap_idle, ap_done, m_if.tvalid, m_if.tdata, m_if.tuser, s_if.tready);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ap_start = 1'b0; place_x0 = '0; place_y0 = '0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = '0; m_if.tready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check_reset_outputs("after_release");
    endtask

    task automatic test_centered;
        int g;
        start_frame(5, 3);
        run_frame(0, 0, 0, 0, -1, g);
        n_cmp++;
        if (g != 0) begin
            n_err++;
            $display("FAIL throughput: got %0d gaps want 0", g);
        end
    endtask

    task automatic test_clamped;
        int g;
        start_frame(15, 18);
        run_frame(0, 0, 0, 0, -1, g);
    endtask

    task automatic test_backpressure;
        int g;
        start_frame(5, 3);
        run_frame(0, 1, 1, 0, -1, g);
    endtask

    task automatic test_source_stall;
        int g;
        start_frame(5, 3);
        run_frame(8, 0, 0, 0, -1, g);
        n_cmp++;
        if (g != 8) begin
            n_err++;
            $display("FAIL stall_gaps: got %0d idle output cycles want 8", g);
        end
    endtask

    task automatic test_reset_mid_frame;
        int g;
        start_frame(5, 3);
        run_frame(0, 0, 0, 150, -1, g);
        @(negedge clk);
        rst_n = 1'b0;
        s_if.tvalid = 1'b0;
        #1;
        check_reset_outputs("mid_frame_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (ap_done !== 1'b0) begin
                n_err++;
                $display("FAIL done_after_abort: got %b want 0", ap_done);
            end
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        sb.delete();
        start_frame(5, 3);
        run_frame(0, 0, 0, 0, -1, g);
    endtask

`ifdef EMBED_SOF_CHECK_EN
    task automatic test_sof_check;
        int g;
        start_frame(5, 3);
        run_frame(0, 0, 0, 0, 7, g);
        start_frame(5, 3);
        #1;
        n_cmp++;
        if (sof_err !== 1'b0) begin
            n_err++;
            $display("FAIL sof_err_clear: got %b want 0", sof_err);
        end
        run_frame(0, 0, 0, 0, -1, g);
    endtask
`endif

    initial begin
        test_reset();
        test_centered();
        test_clamped();
        test_backpressure();
        test_source_stall();
        test_reset_mid_frame();
`ifdef EMBED_SOF_CHECK_EN
        test_sof_check();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
